sec_counter_bcd: RTL
====================

# sec_counter_bcd

Parametrised multi-digit BCD seconds counter with a built-in tick prescaler and active-low 7-segment decode, one digit per HEX field. It is the general successor of the single-digit 0–9 board seconds display. It adds configurable digit count, an arbitrary decimal wrap limit, up/down counting, run/pause, synchronous clear and parallel load, and a wrap pulse for cascading (e.g. seconds into minutes). It sits at the board top level, driving DE-series HEX displays or feeding a further counter stage.

## Interface
- CLK_HZ, 50_000_000, input clock frequency in Hz
- TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ, integer, ≥ 2
- DIGITS, 2, number of BCD digits, 1..6
- MAX, 59, terminal count in decimal, 1..10^DIGITS−1
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- RUN  in  1  level; 1 = prescaler advances and ticks count, 0 = paused (prescaler and digits hold)
- DOWN  in  1  count direction, 0 = up, 1 = down; sampled on each tick
- CLR  in  1  synchronous clear of digits and prescaler
- LOAD  in  1  synchronous parallel load of digits, prescaler cleared
- LOAD_VAL  in  4*DIGITS  BCD load value, digit 0 in [3:0]
- BCD  out  4*DIGITS  current count, BCD, digit 0 (units) in [3:0]
- HEX  out  7*DIGITS  active-low segments {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]
- WRAP  out  1  registered one-cycle pulse on wrap in either direction

## Operation
- Prescaler: counter 0..DIV−1, width $clog2(DIV). It increments only while RUN=1. tick = RUN && (cnt == DIV−1); on tick it returns to 0. While RUN=0 it holds its value, so phase is preserved across a pause.
- Priority each cycle: CLR > LOAD > tick > hold.
- CLR: digits ← 0, prescaler ← 0, WRAP ← 0.
- LOAD: digits ← LOAD_VAL, prescaler ← 0, WRAP ← 0. If any nibble is > 9 or the value is > MAX, digits ← MAX.
- Tick, up: if count == MAX then count ← 0 and WRAP ← 1, else count ← count+1 with BCD ripple carry (a digit at 9 goes to 0 and carries).
- Tick, down: if count == 0 then count ← MAX and WRAP ← 1, else count ← count−1 with BCD borrow (a digit at 0 goes to 9 and borrows).
- WRAP is 0 in every cycle without a wrapping tick.
- Segment decode per digit (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000. Other values → 1111111 (blank, never X).
- HEX is combinational from the digit registers. BCD is the digit registers directly.

## Timing
- Reset (RST_N=0, asynchronous): prescaler 0, digits 0, WRAP 0. BCD=0, and every HEX digit = 1000000.
- Reset deassertion is taken as synchronous to CLK. The first tick occurs DIV RUN-cycles after release.
- Count and WRAP update on the clock edge at which tick is true. BCD/HEX change in the same cycle that WRAP is high.
- From CLR/LOAD with RUN held at 1, the next tick is exactly DIV cycles later.
- A DOWN change between ticks takes effect at the next tick. No glitch and no extra step.
- CLR or LOAD coinciding with a tick suppresses that tick; no WRAP is produced.
- Reset asserted mid-count forces reset values immediately, independent of CLK.

## Configuration
- SEC_CNT_BLANK_EN defined: leading-zero blanking. Any digit above digit 0 that is 0, with all more-significant digits also 0, drives 1111111. Digit 0 is always displayed.
- SEC_CNT_BLANK_EN undefined: all DIGITS digits are always decoded, leading zeros shown as 1000000.

## Test plan
- Reset, default params except CLK_HZ=4, TICK_HZ=1, RUN=1, DOWN=0: BCD steps 00→01 at cycle 4 and 58→59 at cycle 236. At cycle 240, BCD=00 and WRAP=1 for exactly one cycle.
- Down wrap: LOAD_VAL=0x00, LOAD, DOWN=1, RUN=1. After 4 cycles BCD=0x59 and WRAP=1. After 4 more cycles BCD=0x58 and WRAP=0.
- Pause: RUN=0 after 2 prescaler cycles, hold 10 cycles, then RUN=1. The tick arrives 2 cycles after resume; BCD unchanged during the pause.
- LOAD with invalid input: LOAD_VAL=0x7A → BCD=0x59. LOAD_VAL=0x60 → BCD=0x59. LOAD_VAL=0x42 → BCD=0x42, HEX[13:7]=0011001, HEX[6:0]=0100100.
- Simultaneous events: CLR and LOAD asserted in the same cycle as a tick → BCD=0x00, WRAP=0. Async RST_N pulse mid-cycle → BCD=0 before the next edge.
- With SEC_CNT_BLANK_EN and DIGITS=3, MAX=999, BCD=0x007: HEX[20:14]=HEX[13:7]=1111111 and HEX[6:0]=1011000. At 0x000, digit 0 shows 1000000.

Source files
------------

// File: rtl/sec_counter_bcd.sv
// sec_counter_bcd: multi-digit BCD seconds counter with tick prescaler and
// active-low 7-segment decode (gfedcba per digit, digit 0 in the low field).
// Optional feature: define SEC_CNT_BLANK_EN for leading-zero blanking.
module sec_counter_bcd #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX     = 59
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  run_i,
    input  logic                  down_i,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic                  wrap_o
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BW  = 4 * DIGITS;

    typedef logic [BW-1:0] bcd_t;

    // Decimal terminal count converted to BCD at elaboration time.
    function automatic bcd_t to_bcd(input int unsigned v);
        bcd_t        r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1011000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    localparam bcd_t          MaxBcd    = to_bcd(MAX);
    localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    bcd_t          cnt_q, cnt_d;
    logic          wrap_q, wrap_d;

    logic tick;
    logic load_ok;
    bcd_t inc_val;
    bcd_t dec_val;
    logic carry;
    logic borrow;

    assign tick = run_i && (presc_q == PrescLast);

    // Load value is accepted only if every nibble is a decimal digit and it
    // does not exceed the terminal count; valid BCD orders like binary.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_val_i[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
        if (load_val_i > MaxBcd) begin
            load_ok = 1'b0;
        end
    end

    // BCD increment with ripple carry and decrement with ripple borrow.
    always_comb begin
        inc_val = cnt_q;
        dec_val = cnt_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Next state: CLR beats LOAD beats tick; WRAP only on a wrapping tick.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (clr_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (load_i) begin
            presc_d = '0;
            cnt_d   = load_ok ? load_val_i : MaxBcd;
        end else if (tick) begin
            presc_d = '0;
            if (down_i) begin
                if (cnt_q == '0) begin
                    cnt_d  = MaxBcd;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = dec_val;
                end
            end else begin
                if (cnt_q == MaxBcd) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = inc_val;
                end
            end
        end else if (run_i) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bcd_o  = cnt_q;
    assign wrap_o = wrap_q;

`ifdef SEC_CNT_BLANK_EN
    logic lead_zero;

    // Segment decode, blanking zeros above digit 0 while all higher digits are zero.
    always_comb begin
        hex_o     = '1;
        lead_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if ((i != 0) && lead_zero && (cnt_q[4*i +: 4] == 4'd0)) begin
                hex_o[7*i +: 7] = 7'b1111111;
            end else begin
                hex_o[7*i +: 7] = seg7(cnt_q[4*i +: 4]);
                lead_zero       = 1'b0;
            end
        end
    end
`else
    // Segment decode of every digit, leading zeros shown.
    always_comb begin
        hex_o = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            hex_o[7*i +: 7] = seg7(cnt_q[4*i +: 4]);
        end
    end
`endif

endmodule
